// File: rtl/nz_scan_sched_pkg.sv
// Shared definitions for the zero-skipping RegFile read scheduler:
// FSM state encoding and the address-width helper.
package nz_scan_sched_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } state_e;

   // Ceiling log2, never below 1 so a one-entry RegFile still gets an address bit.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) begin
         r = r + 1;
      end
      if (r < 1) begin
         r = 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/nz_scan_sched_lsb_prio_enc.sv
// Lowest-set-bit priority encoder: reports whether any bit is set and the
// index of the least significant one.
module lsb_prio_enc #(
   parameter int WIDTH = 64,
   parameter int IDX_W = 6
) (
   input  logic [WIDTH-1:0] vec_i,
   output logic             any_o,
   output logic [IDX_W-1:0] idx_o
);

   always_comb begin
      any_o = |vec_i;
      idx_o = '0;
      // Scan downward so the lowest set bit is the last one written.
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (vec_i[i]) begin
            idx_o = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/nz_scan_sched.sv
// Zero-skipping read scheduler: snapshots the RegFile zero flags on start and
// streams (addr, data) for each non-zero entry in ascending order.
module nz_scan_sched
   import nz_scan_sched_pkg::*;
#(
   parameter  int BIT_WIDTH = 16,
   parameter  int REG_DEPTH = 64,
   localparam int ADDR_W    = clog2(REG_DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic [ADDR_W:0]      nnz_count,
   input  logic [REG_DEPTH-1:0] zeros,
   output logic                 rf_read_en,
   output logic [ADDR_W-1:0]    rf_read_addr,
   input  logic [BIT_WIDTH-1:0] rf_read_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ADDR_W-1:0]    out_addr,
   output logic [BIT_WIDTH-1:0] out_data
);

   function automatic logic [ADDR_W:0] popcount(input logic [REG_DEPTH-1:0] v);
      logic [ADDR_W:0] s;
      s = '0;
      for (int i = 0; i < REG_DEPTH; i++) begin
         s = s + {{ADDR_W{1'b0}}, v[i]};
      end
      return s;
   endfunction

   state_e                 state_q, state_d;
   logic [REG_DEPTH-1:0]   pend_q, pend_d;
   logic [ADDR_W:0]        nnz_q, nnz_d;
   logic                   done_q, done_d;
   logic                   valid_q, valid_d;
   logic [ADDR_W-1:0]      addr_q, addr_d;
   logic [BIT_WIDTH-1:0]   data_q, data_d;

   logic                   pend_any;
   logic [ADDR_W-1:0]      nxt;
   logic                   stage_free;
   logic                   load;

   lsb_prio_enc #(
      .WIDTH (REG_DEPTH),
      .IDX_W (ADDR_W)
   ) u_enc (
      .vec_i (pend_q),
      .any_o (pend_any),
      .idx_o (nxt)
   );

   // The output stage can take a new entry when empty or being popped this cycle.
   assign stage_free   = !valid_q || out_ready;
   assign load         = (state_q == ST_SCAN) && pend_any && stage_free && !rst;
   assign rf_read_en   = load;
   assign rf_read_addr = load ? nxt : '0;

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      nnz_d   = nnz_q;
      done_d  = 1'b0;
      valid_d = valid_q;
      addr_d  = addr_q;
      data_d  = data_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               pend_d  = ~zeros;
               nnz_d   = popcount(~zeros);
               state_d = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (load) begin
               data_d       = rf_read_data;
               addr_d       = nxt;
               valid_d      = 1'b1;
               pend_d[nxt]  = 1'b0;
            end else if (valid_q && out_ready) begin
               valid_d = 1'b0;
            end
            if (!pend_any && stage_free) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
               valid_d = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pend_q  <= '0;
         nnz_q   <= '0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         nnz_q   <= nnz_d;
         done_q  <= done_d;
         valid_q <= valid_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   assign busy      = (state_q == ST_SCAN);
   assign done      = done_q;
   assign nnz_count = nnz_q;
   assign out_valid = valid_q;
   assign out_addr  = addr_q;
   assign out_data  = data_q;

endmodule
